// File: rtl/ravenoc_edge_sink.sv
// Terminating responder for unused mesh-edge router ports: accepts every flit, checks per-VC framing,
// counts and drops traffic, raises a sticky irq. Define RAVENOC_EDGE_SINK_CAPTURE_EN to capture the first bad flit.
`timescale 1ns/1ps
module ravenoc_edge_sink #(
  parameter int FLIT_WIDTH   = 34,
  parameter int N_VIRT_CHN   = 3,
  parameter int PKT_SZ_WIDTH = 8,
  parameter int CNT_WIDTH    = 16,
  localparam int VC_W        = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
  input  logic                  clk_noc,
  input  logic                  arst_noc,
  input  logic                  flit_valid_i,
  input  logic [VC_W-1:0]       flit_vc_i,
  input  logic [FLIT_WIDTH-1:0] flit_data_i,
  output logic [N_VIRT_CHN-1:0] flit_ready_o,
  input  logic                  clr_i,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic                  irq_o,
  output logic [FLIT_WIDTH-1:0] cap_flit_o,
  output logic [VC_W-1:0]       cap_vc_o
);

  typedef enum logic {IDLE, IN_PKT} state_t;
  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_ONLY = 2'b11
  } flit_type_t;

  flit_type_t              flit_type;
  logic [PKT_SZ_WIDTH-1:0] pkt_sz;
  logic [N_VIRT_CHN-1:0]   vc_err;
  logic [N_VIRT_CHN-1:0]   vc_pkt;
  logic                    any_err;
  logic                    any_pkt;

  assign flit_type = flit_type_t'(flit_data_i[FLIT_WIDTH-1 -: 2]);
  assign pkt_sz    = flit_data_i[FLIT_WIDTH-3 -: PKT_SZ_WIDTH];

  for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
    state_t                  state_q, state_d;
    logic [PKT_SZ_WIDTH-1:0] rem_q, rem_d;
    logic                    hit;
    logic                    err;
    logic                    pkt;
    logic                    restart;

    // An out-of-range VC matches no channel, so it never transfers.
    assign hit = flit_valid_i && (flit_vc_i == VC_W'(v)) && flit_ready_o[v];

    // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      err     = 1'b0;
      pkt     = 1'b0;
      restart = 1'b0;
      if (hit) begin
        if (state_q == IN_PKT) begin
          case (flit_type)
            FT_BODY: begin
              if (rem_q > PKT_SZ_WIDTH'(1)) begin
                rem_d = rem_q - PKT_SZ_WIDTH'(1);
              end else begin
                err     = 1'b1;
                state_d = IDLE;
                rem_d   = '0;
              end
            end
            FT_TAIL: begin
              pkt     = (rem_q == PKT_SZ_WIDTH'(1));
              err     = (rem_q != PKT_SZ_WIDTH'(1));
              state_d = IDLE;
              rem_d   = '0;
            end
            default: begin
              // Truncated packet; the new head is then handled as if arriving in IDLE.
              err     = 1'b1;
              state_d = IDLE;
              rem_d   = '0;
              restart = 1'b1;
            end
          endcase
        end else begin
          restart = 1'b1;
        end

        if (restart) begin
          case (flit_type)
            FT_HEAD: begin
              if (pkt_sz != '0) begin
                state_d = IN_PKT;
                rem_d   = pkt_sz;
              end else begin
                err = 1'b1;
              end
            end
            FT_HEAD_ONLY: pkt = 1'b1;
            default:      err = 1'b1;
          endcase
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_noc or posedge arst_noc) begin
      if (arst_noc) begin
        state_q <= IDLE;
        rem_q   <= '0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
      end
    end

    assign vc_err[v] = err;
    assign vc_pkt[v] = pkt;
  end

  assign any_err = |vc_err;
  assign any_pkt = |vc_pkt;

  // The sink never back-pressures once out of reset.
  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) flit_ready_o <= '0;
    else          flit_ready_o <= '1;
  end

  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      pkt_cnt_o <= '0;
      err_cnt_o <= '0;
      irq_o     <= 1'b0;
    end else if (clr_i) begin
      pkt_cnt_o <= '0;
      err_cnt_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (any_pkt && (pkt_cnt_o != '1)) pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
      if (any_err && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
      if (any_err)                      irq_o     <= 1'b1;
    end
  end

`ifdef RAVENOC_EDGE_SINK_CAPTURE_EN
  logic cap_valid_q;

  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      cap_valid_q <= 1'b0;
      cap_flit_o  <= '0;
      cap_vc_o    <= '0;
    end else if (clr_i) begin
      cap_valid_q <= 1'b0;
      cap_flit_o  <= '0;
      cap_vc_o    <= '0;
    end else if (any_err && !cap_valid_q) begin
      cap_valid_q <= 1'b1;
      cap_flit_o  <= flit_data_i;
      cap_vc_o    <= flit_vc_i;
    end
  end
`else
  logic unused_data;

  assign unused_data = ^flit_data_i;
  assign cap_flit_o  = '0;
  assign cap_vc_o    = '0;
`endif

endmodule

// File: tb/tb_ravenoc_edge_sink.sv
// Scoreboard bench for ravenoc_edge_sink: directed framing cases plus random traffic against a
// per-VC "flits still expected" model; honours RAVENOC_EDGE_SINK_CAPTURE_EN.
`timescale 1ns/1ps
module tb_ravenoc_edge_sink;
  localparam int FW  = 34;
  localparam int NVC = 3;
  localparam int SZW = 8;
  localparam int CW  = 16;
  localparam int VCW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HO   = 2'b11;

  logic           clk_noc = 1'b0;
  logic           arst_noc = 1'b1;
  logic           flit_valid_i = 1'b0;
  logic [VCW-1:0] flit_vc_i = '0;
  logic [FW-1:0]  flit_data_i = '0;
  logic [NVC-1:0] flit_ready_o;
  logic           clr_i = 1'b0;
  logic [CW-1:0]  pkt_cnt_o;
  logic [CW-1:0]  err_cnt_o;
  logic           irq_o;
  logic [FW-1:0]  cap_flit_o;
  logic [VCW-1:0] cap_vc_o;

  ravenoc_edge_sink dut (
    .clk_noc      (clk_noc),
    .arst_noc     (arst_noc),
    .flit_valid_i (flit_valid_i),
    .flit_vc_i    (flit_vc_i),
    .flit_data_i  (flit_data_i),
    .flit_ready_o (flit_ready_o),
    .clr_i        (clr_i),
    .pkt_cnt_o    (pkt_cnt_o),
    .err_cnt_o    (err_cnt_o),
    .irq_o        (irq_o),
    .cap_flit_o   (cap_flit_o),
    .cap_vc_o     (cap_vc_o)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct {
    int            pkt;
    int            err;
    bit            irq;
    logic [FW-1:0] cap_flit;
    int            cap_vc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: flits still owed by the open packet on each VC (0 = no packet open).
  int            left[NVC];
  int            m_pkt, m_err;
  bit            m_irq, m_cap_v;
  logic [FW-1:0] m_cap_flit;
  int            m_cap_vc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NVC; i++) left[i] = 0;
    m_pkt = 0; m_err = 0; m_irq = 0; m_cap_v = 0; m_cap_flit = '0; m_cap_vc = 0;
  endtask

  task automatic model_step(input bit valid, input int vc, input logic [FW-1:0] d, input bit clr);
    bit       err = 0;
    bit       pkt = 0;
    bit       fresh;
    logic [1:0] t = d[FW-1 -: 2];
    int       sz = int'(d[FW-3 -: SZW]);
    exp_t     e;
    if (valid) begin
      fresh = (left[vc] == 0);
      if (!fresh) begin
        if (t == T_BODY) begin
          if (left[vc] > 1) left[vc] = left[vc] - 1;
          else begin err = 1; left[vc] = 0; end
        end else if (t == T_TAIL) begin
          if (left[vc] == 1) pkt = 1; else err = 1;
          left[vc] = 0;
        end else begin
          err = 1; left[vc] = 0; fresh = 1;
        end
      end
      if (fresh) begin
        if (t == T_HEAD) begin
          if (sz > 0) left[vc] = sz; else err = 1;
        end else if (t == T_HO) pkt = 1;
        else err = 1;
      end
    end
    if (clr) begin
      m_pkt = 0; m_err = 0; m_irq = 0; m_cap_v = 0; m_cap_flit = '0; m_cap_vc = 0;
    end else begin
      if (pkt && m_pkt < CNT_MAX) m_pkt++;
      if (err && m_err < CNT_MAX) m_err++;
      if (err) m_irq = 1;
      if (err && !m_cap_v) begin m_cap_v = 1; m_cap_flit = d; m_cap_vc = vc; end
    end
    if (valid || clr) begin
      e.pkt = m_pkt; e.err = m_err; e.irq = m_irq;
`ifdef RAVENOC_EDGE_SINK_CAPTURE_EN
      e.cap_flit = m_cap_flit; e.cap_vc = m_cap_vc;
`else
      e.cap_flit = '0; e.cap_vc = 0;
`endif
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int sz);
    logic [FW-SZW-3:0] pay = FW'($urandom);
    return {t, SZW'(sz), pay};
  endfunction

  // One cycle of stimulus, starting and ending on a falling edge.
  task automatic cycle(input bit valid, input int vc, input logic [FW-1:0] d, input bit clr);
    flit_valid_i = valid;
    flit_vc_i    = VCW'(vc);
    flit_data_i  = d;
    clr_i        = clr;
    model_step(valid, vc, d, clr);
    @(negedge clk_noc);
    flit_valid_i = 1'b0;
    clr_i        = 1'b0;
  endtask

  task automatic send(input int vc, input logic [1:0] t, input int sz);
    cycle(1'b1, vc, mk(t, sz), 1'b0);
  endtask

  task automatic clear();
    cycle(1'b0, 0, '0, 1'b1);
  endtask

  task automatic do_reset();
    arst_noc = 1'b1;
    model_reset();
    #1;
    check("rst_ready", 64'(flit_ready_o), 64'(0));
    check("rst_pkt", 64'(pkt_cnt_o), 64'(0));
    check("rst_err", 64'(err_cnt_o), 64'(0));
    check("rst_irq", 64'(irq_o), 64'(0));
    check("rst_cap_flit", 64'(cap_flit_o), 64'(0));
    check("rst_cap_vc", 64'(cap_vc_o), 64'(0));
    repeat (2) @(negedge clk_noc);
    arst_noc = 1'b0;
    check("ready_held_low", 64'(flit_ready_o), 64'(0));
    @(negedge clk_noc);
    check("ready_after_rst", 64'(flit_ready_o), 64'({NVC{1'b1}}));
  endtask

  // Monitor: every edge that carried a flit or a clear must match the next queued expectation.
  initial begin
    bit   ev;
    exp_t e;
    forever begin
      @(posedge clk_noc);
      ev = !arst_noc && (flit_valid_i || clr_i);
      #1;
      if (ev) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_underflow: DUT event with no expected entry (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_pkt_cnt", 64'(pkt_cnt_o), 64'(e.pkt));
          check("sb_err_cnt", 64'(err_cnt_o), 64'(e.err));
          check("sb_irq", 64'(irq_o), 64'(e.irq));
          check("sb_cap_flit", 64'(cap_flit_o), 64'(e.cap_flit));
          check("sb_cap_vc", 64'(cap_vc_o), 64'(e.cap_vc));
          check("sb_ready", 64'(flit_ready_o), 64'({NVC{1'b1}}));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Well-formed 3-flit packet on VC0.
    send(0, T_HEAD, 2); send(0, T_BODY, 0); send(0, T_TAIL, 0);
    // Orphan body on VC1.
    send(1, T_BODY, 0);
    clear();

    // VC2 head-only flits interleaved with every VC0 flit.
    send(0, T_HEAD, 3); send(2, T_HO, 0);
    send(0, T_BODY, 0); send(2, T_HO, 0);
    send(0, T_BODY, 0); send(2, T_HO, 0);
    send(0, T_BODY, 0); send(2, T_HO, 0);
    send(0, T_TAIL, 0);
    clear();

    // Tail arrives early: length error, then VC0 is idle again.
    send(0, T_HEAD, 3); send(0, T_BODY, 0); send(0, T_TAIL, 0);
    send(0, T_HO, 0);
    clear();

    // Truncation by a new head, which then completes normally.
    send(0, T_HEAD, 2); send(0, T_BODY, 0); send(0, T_HEAD, 1); send(0, T_TAIL, 0);
    // Zero-size head and head-only while a packet is open.
    send(2, T_HEAD, 0); send(2, T_HEAD, 1); send(2, T_HO, 0);
    clear();

    // Reset mid-packet: the following tail is an orphan.
    send(1, T_HEAD, 2); send(1, T_BODY, 0);
    do_reset();
    send(1, T_TAIL, 0);
    clear();

    // Error counter saturation, then clear racing an orphan.
    for (int i = 0; i < CNT_MAX; i++) send(1, T_TAIL, 0);
    send(1, T_TAIL, 0);
    cycle(1'b1, 1, mk(T_TAIL, 0), 1'b1);
    send(2, T_BODY, 0);
    clear();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         v   = ($urandom_range(0, 9) < 7);
      int         vc  = $urandom_range(0, NVC - 1);
      logic [1:0] t   = 2'($urandom_range(0, 3));
      int         sz  = $urandom_range(0, 3);
      bit         clr = ($urandom_range(0, 99) == 0);
      cycle(v, vc, mk(t, sz), clr);
    end

    repeat (3) @(negedge clk_noc);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
